// File: rtl/sum_every_n_pkg.sv
// Shared types and width helpers for the sum_every_n group accumulator.
// Parameter-independent so both the top and the length counter can import it.
package sum_every_n_pkg;

    typedef enum logic {
        SEN_UNSIGNED = 1'b0,
        SEN_SIGNED   = 1'b1
    } sen_mode_e;

    localparam int SEN_DEF_IW   = 8;
    localparam int SEN_DEF_NMAX = 8;

    function automatic int calc_lw(input int nmax);
        return $clog2(nmax + 1);
    endfunction

    // Result width: a group of up to nmax samples can never overflow this.
    function automatic int calc_ow(input int iw, input int nmax);
        return iw + $clog2(nmax);
    endfunction

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned nmax);
        if ((len == 32'd0) || (len > nmax)) begin
            return nmax;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/sen_len_counter.sv
// Group-length bookkeeping: clamps and latches the length at group start,
// counts accepted samples and decides when the current group closes.
module sen_len_counter
    import sum_every_n_pkg::*;
#(
    parameter int NMAX = SEN_DEF_NMAX,
    parameter int LW   = calc_lw(NMAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [LW-1:0] len_i,
    input  logic          accept_i,
    input  logic          flush_i,
    output logic [LW-1:0] cnt_o,
    output logic          close_o
);

    logic [LW-1:0] cnt_q;
    logic [LW-1:0] cnt_d;
    logic [LW-1:0] len_q;
    logic [LW-1:0] len_d;
    logic [LW-1:0] len_clamped;
    logic [LW-1:0] len_eff;
    logic [LW-1:0] cnt_n;
    logic          close;

    // Next count, effective length (same-cycle latch when idle) and close decision.
    always_comb begin
        len_clamped = LW'(clamp_len(32'(len_i), 32'(NMAX)));
        if (cnt_q == {LW{1'b0}}) begin
            len_eff = len_clamped;
        end else begin
            len_eff = len_q;
        end

        if (accept_i) begin
            cnt_n = cnt_q + {{(LW-1){1'b0}}, 1'b1};
        end else begin
            cnt_n = cnt_q;
        end

        close = (accept_i && (cnt_n == len_eff)) ||
                (flush_i && ((cnt_q != {LW{1'b0}}) || accept_i));

        if (close) begin
            cnt_d = {LW{1'b0}};
        end else begin
            cnt_d = cnt_n;
        end

        // Length changes while a group is open are deliberately ignored.
        if (accept_i && (cnt_q == {LW{1'b0}})) begin
            len_d = len_eff;
        end else begin
            len_d = len_q;
        end
    end

    // Count and latched-length registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {LW{1'b0}};
            len_q <= {LW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign close_o = close;

endmodule

// File: rtl/sum_every_n.sv
// Streaming group accumulator: sums each run of L valid samples (L runtime
// selectable, flush closes a partial group) and strobes one result per group.
module sum_every_n
    import sum_every_n_pkg::*;
#(
    parameter  int IW     = SEN_DEF_IW,
    parameter  int NMAX   = SEN_DEF_NMAX,
    parameter  int SIGNED = 0,
    localparam int LW     = calc_lw(NMAX),
    localparam int OW     = calc_ow(IW, NMAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [LW-1:0] i_len,
    input  logic          i_dval,
    input  logic [IW-1:0] i,
    input  logic          i_flush,
    output logic          o_dval,
    output logic [OW-1:0] o,
    output logic [LW-1:0] o_cnt,
    output logic          o_busy
);

    localparam sen_mode_e MODE = (SIGNED != 0) ? SEN_SIGNED : SEN_UNSIGNED;

    logic [LW-1:0] cnt;
    logic          close;
    logic [LW-1:0] cnt_n;
    logic [OW-1:0] ext;
    logic [OW-1:0] sum_n;

    logic [OW-1:0] acc_q;
    logic [OW-1:0] acc_d;
    logic          o_dval_q;
    logic          o_dval_d;
    logic [OW-1:0] o_q;
    logic [OW-1:0] o_d;
    logic [LW-1:0] o_cnt_q;
    logic [LW-1:0] o_cnt_d;
    logic          o_busy_q;
    logic          o_busy_d;

    sen_len_counter #(
        .NMAX (NMAX),
        .LW   (LW)
    ) u_len_counter (
        .clk      (clk),
        .rst      (rst),
        .len_i    (i_len),
        .accept_i (i_dval),
        .flush_i  (i_flush),
        .cnt_o    (cnt),
        .close_o  (close)
    );

    // Widen the sample to the result width according to the signedness mode.
    always_comb begin
        case (MODE)
            SEN_SIGNED:   ext = {{(OW-IW){i[IW-1]}}, i};
            SEN_UNSIGNED: ext = {{(OW-IW){1'b0}}, i};
            default:      ext = {OW{1'b0}};
        endcase
    end

    // Accumulate, and on close hand the sum/count to the output registers.
    always_comb begin
        if (i_dval) begin
            sum_n = acc_q + ext;
            cnt_n = cnt + {{(LW-1){1'b0}}, 1'b1};
        end else begin
            sum_n = acc_q;
            cnt_n = cnt;
        end

        o_dval_d = close;
        if (close) begin
            acc_d    = {OW{1'b0}};
            o_d      = sum_n;
            o_cnt_d  = cnt_n;
            o_busy_d = 1'b0;
        end else begin
            acc_d    = sum_n;
            o_d      = o_q;
            o_cnt_d  = o_cnt_q;
            o_busy_d = (cnt_n != {LW{1'b0}});
        end
    end

    // Accumulator and registered outputs; reset discards any partial group.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= {OW{1'b0}};
            o_dval_q <= 1'b0;
            o_q      <= {OW{1'b0}};
            o_cnt_q  <= {LW{1'b0}};
            o_busy_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            o_dval_q <= o_dval_d;
            o_q      <= o_d;
            o_cnt_q  <= o_cnt_d;
            o_busy_q <= o_busy_d;
        end
    end

    assign o_dval = o_dval_q;
    assign o      = o_q;
    assign o_cnt  = o_cnt_q;
    assign o_busy = o_busy_q;

endmodule

// File: tb/tb_sum_every_n.sv
// Bench for sum_every_n: unsigned and signed instances share one stimulus
// stream and are compared every cycle against a queue-based group model.
module tb_sum_every_n;

    localparam int IW   = 8;
    localparam int NMAX = 8;
    localparam int LW   = 4;
    localparam int OW   = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LW-1:0] i_len = '0;
    logic          i_dval = 1'b0;
    logic [IW-1:0] i = '0;
    logic          i_flush = 1'b0;

    logic          o_dval_u, o_busy_u, o_dval_s, o_busy_s;
    logic [OW-1:0] o_u, o_s;
    logic [LW-1:0] o_cnt_u, o_cnt_s;

    int checks = 0;
    int errors = 0;

    int grp[$];
    int grp_len = 0;
    int exp_dval = 0, exp_ou = 0, exp_os = 0, exp_cnt = 0, exp_busy = 0;
    int stepno = 0;

    always #5 clk = ~clk;

    sum_every_n #(.IW(IW), .NMAX(NMAX), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .i_len(i_len), .i_dval(i_dval), .i(i), .i_flush(i_flush),
        .o_dval(o_dval_u), .o(o_u), .o_cnt(o_cnt_u), .o_busy(o_busy_u)
    );

    sum_every_n #(.IW(IW), .NMAX(NMAX), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .i_len(i_len), .i_dval(i_dval), .i(i), .i_flush(i_flush),
        .o_dval(o_dval_s), .o(o_s), .o_cnt(o_cnt_s), .o_busy(o_busy_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, stepno, obs, exp);
        end
    endtask

    // Group model: samples of the open group live in a queue; the group closes
    // when it holds its length or a flush arrives while it has data.
    task automatic model(input bit r, input bit dv, input bit fl, input int ln, input int smp);
        int su;
        int ss;
        if (r) begin
            grp.delete();
            exp_dval = 0; exp_ou = 0; exp_os = 0; exp_cnt = 0;
        end else begin
            exp_dval = 0;
            if (dv) begin
                if (grp.size() == 0) grp_len = (ln == 0 || ln > NMAX) ? NMAX : ln;
                grp.push_back(smp & 255);
            end
            if ((dv && grp.size() == grp_len) || (fl && grp.size() > 0)) begin
                su = 0; ss = 0;
                foreach (grp[k]) begin
                    su += grp[k];
                    ss += (grp[k] >= 128) ? grp[k] - 256 : grp[k];
                end
                exp_dval = 1;
                exp_cnt  = grp.size();
                exp_ou   = su & ((1 << OW) - 1);
                exp_os   = ss & ((1 << OW) - 1);
                grp.delete();
            end
        end
        exp_busy = (grp.size() > 0) ? 1 : 0;
    endtask

    task automatic step(input bit r, input bit dv, input bit fl, input int ln, input int smp);
        @(negedge clk);
        rst = r; i_dval = dv; i_flush = fl; i_len = LW'(ln); i = IW'(smp);
        model(r, dv, fl, ln, smp);
        @(posedge clk);
        #1;
        stepno++;
        check("dval_u", 32'(o_dval_u), 32'(exp_dval));
        check("o_u",    32'(o_u),      32'(exp_ou));
        check("cnt_u",  32'(o_cnt_u),  32'(exp_cnt));
        check("busy_u", 32'(o_busy_u), 32'(exp_busy));
        check("dval_s", 32'(o_dval_s), 32'(exp_dval));
        check("o_s",    32'(o_s),      32'(exp_os));
        check("cnt_s",  32'(o_cnt_s),  32'(exp_cnt));
        check("busy_s", 32'(o_busy_s), 32'(exp_busy));
    endtask

    initial begin
        // Reset state.
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);

        // Length 3, samples 1..9 back to back.
        for (int k = 1; k <= 9; k++) step(1'b0, 1'b1, 1'b0, 3, k);
        check("t1_last_sum", 32'(o_u), 32'd24);
        step(1'b0, 1'b0, 1'b0, 3, 0);

        // Partial group closed by flush, then a flush on an idle block.
        step(1'b0, 1'b1, 1'b0, 3, 5);
        step(1'b0, 1'b1, 1'b0, 3, 7);
        step(1'b0, 1'b0, 1'b1, 3, 0);
        check("t2_partial_sum", 32'(o_u), 32'd12);
        step(1'b0, 1'b0, 1'b1, 3, 0);
        step(1'b0, 1'b0, 1'b0, 3, 0);

        // Signed vs unsigned extension of the same bit patterns.
        step(1'b0, 1'b1, 1'b0, 4, 128);
        step(1'b0, 1'b1, 1'b0, 4, 128);
        step(1'b0, 1'b1, 1'b0, 4, 127);
        step(1'b0, 1'b1, 1'b0, 4, 255);
        check("t3_signed", 32'(o_s), 32'd1918);
        check("t3_unsigned", 32'(o_u), 32'd638);

        // Length 0 and 9 clamp to NMAX; mid-group length change ignored.
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, (k == 0) ? 0 : 2, 255);
        check("t4_clamp0", 32'(o_u), 32'd2040);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, (k == 0) ? 9 : 2, 255);
        check("t4_clamp9_cnt", 32'(o_cnt_u), 32'd8);

        // Flush on the terminal sample yields a single strobe; then length 1.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, (k == 3), 4, 10 + k);
        check("t5_cnt", 32'(o_cnt_u), 32'd4);
        step(1'b0, 1'b0, 1'b0, 4, 0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1, 40 + k);

        // Reset mid-group discards it; the next three samples form a fresh group.
        step(1'b0, 1'b1, 1'b0, 3, 1);
        step(1'b0, 1'b1, 1'b0, 3, 2);
        step(1'b1, 1'b0, 1'b0, 3, 0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 3, 20 + k);
        check("t6_fresh", 32'(o_u), 32'd63);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
